eaf_request_queue: RTL

- Front end of the Evicted Address Filter (EAF), placed between the cache controller and the EAF bloom-filter priority/control block.
- Accepts eviction-insert requests into a small FIFO and miss-test requests into a single holding register. Serializes them onto the EAF's single-operation interface; tests take priority over inserts.
- Counts completed inserts and issues a one-cycle filter clear when the EAF reaches its capacity, so the filter tracks only the last max_num_of_entries evictions.

---
 rtl/eaf_request_queue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/eaf_request_queue.sv
// Front end of the Evicted Address Filter: queues evictions, holds one miss test and
// serializes both onto the single-operation EAF port (tests first), clearing the filter each epoch.
module eaf_request_queue #(
  parameter int addr_length         = 32,
  parameter int fifo_depth          = 4,
  parameter int max_num_of_entries  = 8,
  parameter int num_of_counter_bits = $clog2(max_num_of_entries + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           evict_valid_i,
  input  logic [addr_length-1:0]         evict_addr_i,
  output logic                           evict_ready_o,
  input  logic                           test_valid_i,
  input  logic [addr_length-1:0]         test_addr_i,
  output logic                           test_ready_o,
  output logic                           test_done_o,
  output logic                           test_hit_o,
  output logic [addr_length-1:0]         eaf_mem_addr_o,
  output logic                           eaf_insert_o,
  output logic                           eaf_test_o,
  output logic                           eaf_clear_o,
  input  logic                           eaf_done_i,
  input  logic                           eaf_addr_exists_i,
  output logic [num_of_counter_bits-1:0] insert_count_o
);
  localparam int PTR_W = $clog2(fifo_depth);
  localparam int OCC_W = $clog2(fifo_depth + 1);

  typedef enum logic [1:0] {IDLE, TEST, INSERT, CLEAR} state_t;

  logic [addr_length-1:0]         fifo_mem_q [fifo_depth];
  logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]               occ_q, occ_d;
  logic                           test_pending_q;
  logic [addr_length-1:0]         test_addr_q;
  state_t                         state_q;
  logic [num_of_counter_bits-1:0] cnt_q, cnt_inc;
  logic                           eaf_insert_q, eaf_test_q, eaf_clear_q;
  logic                           test_done_q, test_hit_q;
  logic [addr_length-1:0]         eaf_addr_q;
  logic                           fifo_full, fifo_empty, push, pop, test_acc;

  // Readiness comes from registered occupancy only: a pop never frees a slot in the same cycle.
  always_comb begin
    fifo_full     = (occ_q == OCC_W'(fifo_depth));
    fifo_empty    = (occ_q == '0);
    evict_ready_o = !rst && !fifo_full;
    test_ready_o  = !rst && !test_pending_q;
    push          = evict_valid_i && evict_ready_o;
    test_acc      = test_valid_i && test_ready_o;
    pop           = (state_q == INSERT) && eaf_done_i;
    cnt_inc       = cnt_q + num_of_counter_bits'(1);
    occ_d         = occ_q;
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (pop && !push) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= evict_addr_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      test_pending_q <= 1'b0;
      test_addr_q    <= '0;
    end else if (test_acc) begin
      test_pending_q <= 1'b1;
      test_addr_q    <= test_addr_i;
    end else if (state_q == TEST && eaf_done_i) begin
      test_pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      eaf_insert_q <= 1'b0;
      eaf_test_q   <= 1'b0;
      eaf_clear_q  <= 1'b0;
      eaf_addr_q   <= '0;
      test_done_q  <= 1'b0;
      test_hit_q   <= 1'b0;
    end else begin
      test_done_q <= 1'b0;
      eaf_clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (test_pending_q) begin
            state_q    <= TEST;
            eaf_test_q <= 1'b1;
            eaf_addr_q <= test_addr_q;
          end else if (!fifo_empty) begin
            state_q      <= INSERT;
            eaf_insert_q <= 1'b1;
            eaf_addr_q   <= fifo_mem_q[rd_ptr_q];
          end
        end
        TEST: begin
          if (eaf_done_i) begin
            state_q     <= IDLE;
            eaf_test_q  <= 1'b0;
            eaf_addr_q  <= '0;
            test_hit_q  <= eaf_addr_exists_i;
            test_done_q <= 1'b1;
          end
        end
        INSERT: begin
          if (eaf_done_i) begin
            eaf_insert_q <= 1'b0;
            eaf_addr_q   <= '0;
            cnt_q        <= cnt_inc;
            if (cnt_inc == num_of_counter_bits'(max_num_of_entries)) begin
              state_q     <= CLEAR;
              eaf_clear_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        CLEAR: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eaf_insert_o   = eaf_insert_q;
  assign eaf_test_o     = eaf_test_q;
  assign eaf_clear_o    = eaf_clear_q;
  assign eaf_mem_addr_o = eaf_addr_q;
  assign test_done_o    = test_done_q;
  assign test_hit_o     = test_hit_q;
  assign insert_count_o = cnt_q;
endmodule
